wb_rr_master_arbiter: RTL

- Shares one Wishbone B3 slave-side bus between num_masters masters, using registered round-robin arbitration.
- A grant is held for a master's whole cyc_o assertion, so classic and burst (cti/bte) cycles stay atomic.
- A bus watchdog aborts stalled cycles with err to the owning master.
- Sits between the CPU/debug/DMA masters and the slave-select fabric in the top-level bus.

---
 rtl/wb_rr_master_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/wb_rr_master_arbiter.sv
// wb_rr_master_arbiter: shares one Wishbone B3 slave bus between num_masters masters.
// Registered round-robin grant held for the owner's whole cyc; watchdog aborts stalled cycles with err.
// Ports: wbm_* per-master slices (master k at slice k), wbs_* shared slave bus, grant_o one-hot owner,
// timeout_o one-cycle abort pulse. Latency: request in cycle t drives the slave bus from cycle t+1.
module wb_rr_master_arbiter #(
  parameter int num_masters  = 4,
  parameter int wb_adr_width = 32,
  parameter int wb_dat_width = 32,
  parameter int wdog_width   = 8
) (
  input  logic                                wb_clk,
  input  logic                                wb_rst_n,
  // master side
  input  logic [num_masters*wb_adr_width-1:0] wbm_adr_o,
  input  logic [num_masters*wb_dat_width-1:0] wbm_dat_o,
  input  logic [num_masters*4-1:0]            wbm_sel_o,
  input  logic [num_masters-1:0]              wbm_we_o,
  input  logic [num_masters-1:0]              wbm_cyc_o,
  input  logic [num_masters-1:0]              wbm_stb_o,
  input  logic [num_masters*3-1:0]            wbm_cti_o,
  input  logic [num_masters*2-1:0]            wbm_bte_o,
  output logic [wb_dat_width-1:0]             wbm_dat_i,
  output logic [num_masters-1:0]              wbm_ack_i,
  output logic [num_masters-1:0]              wbm_err_i,
  output logic [num_masters-1:0]              wbm_rty_i,
  // slave side
  output logic [wb_adr_width-1:0]             wbs_adr_i,
  output logic [wb_dat_width-1:0]             wbs_dat_i,
  output logic [3:0]                          wbs_sel_i,
  output logic                                wbs_we_i,
  output logic                                wbs_cyc_i,
  output logic                                wbs_stb_i,
  output logic [2:0]                          wbs_cti_i,
  output logic [1:0]                          wbs_bte_i,
  input  logic [wb_dat_width-1:0]             wbs_dat_o,
  input  logic                                wbs_ack_o,
  input  logic                                wbs_err_o,
  input  logic                                wbs_rty_o,
  // status
  output logic [num_masters-1:0]              grant_o,
  output logic                                timeout_o
);

  localparam int iw = (num_masters > 1) ? $clog2(num_masters) : 1;
  // Value one below all-ones: a stall seen at this count is the one that reaches the timeout.
  localparam logic [wdog_width-1:0] wdog_last = {{(wdog_width-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, BUSY, ABORT, DRAIN} state_t;

  state_t                  state, state_nxt;
  logic [num_masters-1:0]  grant, grant_nxt;
  logic [iw-1:0]           owner, owner_nxt;
  logic [iw-1:0]           last_owner, last_owner_nxt;
  logic [wdog_width-1:0]   wdog, wdog_nxt;

  logic                    req_found;
  logic [iw-1:0]           req_idx;
  logic                    owner_cyc;
  logic                    owner_stb;
  logic                    slave_rsp;

  function automatic logic [iw-1:0] wrap_idx(input int v);
    return iw'(v % num_masters);
  endfunction

  assign owner_cyc = wbm_cyc_o[owner];
  assign owner_stb = wbm_stb_o[owner];
  assign slave_rsp = wbs_ack_o | wbs_err_o | wbs_rty_o;

  // Round-robin search starting just after the previous owner.
  always_comb begin
    req_found = 1'b0;
    req_idx   = last_owner;
    for (int i = 1; i <= num_masters; i++) begin
      if (!req_found && wbm_cyc_o[wrap_idx(int'(last_owner) + i)]) begin
        req_found = 1'b1;
        req_idx   = wrap_idx(int'(last_owner) + i);
      end
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      owner      <= '0;
      last_owner <= iw'(num_masters - 1);
      wdog       <= '0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      wdog       <= wdog_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    wdog_nxt       = '0;  // cleared everywhere except while stalling in BUSY
    case (state)
      IDLE: begin
        if (req_found) begin
          state_nxt          = BUSY;
          owner_nxt          = req_idx;
          grant_nxt          = '0;
          grant_nxt[req_idx] = 1'b1;
        end
      end
      BUSY: begin
        if (!owner_cyc) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          grant_nxt      = '0;
        end else if (owner_stb && !slave_rsp) begin
          // A response in the compare cycle wins because slave_rsp gates this branch.
          if (wdog == wdog_last) begin
            state_nxt = ABORT;
          end else begin
            wdog_nxt = wdog + 1'b1;
          end
        end
      end
      ABORT: begin
        state_nxt = DRAIN;
      end
      DRAIN: begin
        if (!owner_cyc) begin
          state_nxt      = IDLE;
          last_owner_nxt = owner;
          grant_nxt      = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // Bus mux and response routing; everything idles to 0 outside BUSY so an
  // asynchronous reset drops wbs_cyc_i immediately.
  always_comb begin
    wbs_adr_i = '0;
    wbs_dat_i = '0;
    wbs_sel_i = '0;
    wbs_we_i  = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_cti_i = '0;
    wbs_bte_i = '0;
    wbm_ack_i = '0;
    wbm_err_i = '0;
    wbm_rty_i = '0;
    if (state == BUSY) begin
      wbs_adr_i        = wbm_adr_o[int'(owner)*wb_adr_width +: wb_adr_width];
      wbs_dat_i        = wbm_dat_o[int'(owner)*wb_dat_width +: wb_dat_width];
      wbs_sel_i        = wbm_sel_o[int'(owner)*4 +: 4];
      wbs_we_i         = wbm_we_o[owner];
      wbs_cyc_i        = owner_cyc;
      wbs_stb_i        = owner_stb;
      wbs_cti_i        = wbm_cti_o[int'(owner)*3 +: 3];
      wbs_bte_i        = wbm_bte_o[int'(owner)*2 +: 2];
      wbm_ack_i[owner] = wbs_ack_o;
      wbm_err_i[owner] = wbs_err_o;
      wbm_rty_i[owner] = wbs_rty_o;
    end
    if (state == ABORT) begin
      wbm_err_i[owner] = 1'b1;
    end
  end

  assign wbm_dat_i = wbs_dat_o;
  assign grant_o   = grant;
  assign timeout_o = (state == ABORT);

endmodule
